// File: rtl/vga_sync_gen.sv
// Raster timing source: divided pixel tick, pix_x/pix_y counters, hsync/vsync/video_on.
// Latency: sync/video_on registered from next counter values, aligned with pix_x/pix_y.
// Backpressure: none; free-running generator, consumers sample on p_tick.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   hsync/vsync  active-low sync pulses
//   video_on     1 while (pix_x,pix_y) is inside the visible area
//   p_tick       one-clk pulse per pixel advance
//   pix_x/pix_y  current column/row
//   frame_tick   one-clk pulse after the (H_TOTAL-1,V_TOTAL-1)->(0,0) wrap;
//                only generated when VGA_FRAME_TICK_EN is defined, else tied 0.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // A 1-bit divider is kept even for CLK_DIV=1 so the vector is never zero-width.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;

    always_comb begin
        div_nxt  = (div == DIV_MAX) ? '0 : div + 1'b1;
        // p_tick is registered, so it is raised on the edge that lands div on its last count.
        tick_nxt = (div_nxt == DIV_MAX);

        x_nxt = pix_x;
        y_nxt = pix_y;
        if (p_tick) begin
            if (pix_x == H_MAX) begin
                x_nxt = '0;
                // Line and frame wrap happen together: no (0,V_TOTAL) state exists.
                y_nxt = (pix_y == V_MAX) ? '0 : pix_y + 10'd1;
            end else begin
                x_nxt = pix_x + 10'd1;
            end
        end
    end

    // Sync and blanking are computed from the next counters so they change on the
    // same edge as pix_x/pix_y and renderers see zero skew between them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            p_tick   <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            div      <= div_nxt;
            p_tick   <= tick_nxt;
            pix_x    <= x_nxt;
            pix_y    <= y_nxt;
            hsync    <= !((x_nxt >= HS_START) && (x_nxt <= HS_END));
            vsync    <= !((y_nxt >= VS_START) && (y_nxt <= VS_END));
            video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_wrap;

    assign frame_wrap = p_tick && (pix_x == H_MAX) && (pix_y == V_MAX);

    // Set on the wrap edge itself, so it is high during the first (0,0) cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

`ifdef VGA_FRAME_TICK_EN
    localparam bit FT_EN = 1'b1;
`else
    localparam bit FT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // Instance A: default 640x480 timing, CLK_DIV=4.
    logic       a_hsync, a_vsync, a_video_on, a_p_tick, a_frame_tick;
    logic [9:0] a_pix_x, a_pix_y;
    // Instance B: tiny raster (15x12 totals, CLK_DIV=1) so full frames fit the run.
    logic       b_hsync, b_vsync, b_video_on, b_p_tick, b_frame_tick;
    logic [9:0] b_pix_x, b_pix_y;

    vga_sync_gen u_dut (
        .clk(clk), .reset(rst_a), .hsync(a_hsync), .vsync(a_vsync),
        .video_on(a_video_on), .p_tick(a_p_tick), .pix_x(a_pix_x),
        .pix_y(a_pix_y), .frame_tick(a_frame_tick)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(1)
    ) u_small (
        .clk(clk), .reset(rst_b), .hsync(b_hsync), .vsync(b_vsync),
        .video_on(b_video_on), .p_tick(b_p_tick), .pix_x(b_pix_x),
        .pix_y(b_pix_y), .frame_tick(b_frame_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit pt;
        bit ft;
    } exp_t;

    // Pixel ticks completed after k clk edges since reset release.
    function automatic int ticks(input int k, input int d);
        if (k <= 0) return 0;
        if (d == 1) return k - 1;   // p_tick is low during reset, first advance on edge 2
        return k / d;
    endfunction

    // Expected outputs after k edges since release, from raster arithmetic alone.
    function automatic exp_t model(input int k, input int d,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        exp_t e;
        int ht, vt, t, tp;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        if (k == 0) begin
            e.x = 0; e.y = 0; e.hs = 1; e.vs = 1; e.von = 0; e.pt = 0; e.ft = 0;
            return e;
        end
        t  = ticks(k, d);
        tp = ticks(k - 1, d);
        e.x   = t % ht;
        e.y   = (t / ht) % vt;
        e.hs  = !(e.x >= hd + hf && e.x < hd + hf + hs);
        e.vs  = !(e.y >= vd + vf && e.y < vd + vf + vs);
        e.von = (e.x < hd) && (e.y < vd);
        e.pt  = (d == 1) ? 1'b1 : ((k % d) == d - 1);
        e.ft  = FT_EN && (t > tp) && (t % (ht * vt) == 0);
        return e;
    endfunction

    int k_a = 0;
    int k_b = 0;
    always @(posedge clk) begin
        if (rst_a) k_a = 0; else k_a = k_a + 1;
        if (rst_b) k_b = 0; else k_b = k_b + 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(rst_a ? 0 : k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = model(rst_b ? 0 : k_b, 1, 8, 2, 3, 2, 6, 2, 2, 2);
        chk("a.pix_x",      a_pix_x,      ea.x);
        chk("a.pix_y",      a_pix_y,      ea.y);
        chk("a.hsync",      a_hsync,      ea.hs);
        chk("a.vsync",      a_vsync,      ea.vs);
        chk("a.video_on",   a_video_on,   ea.von);
        chk("a.p_tick",     a_p_tick,     ea.pt);
        chk("a.frame_tick", a_frame_tick, ea.ft);
        chk("b.pix_x",      b_pix_x,      eb.x);
        chk("b.pix_y",      b_pix_y,      eb.y);
        chk("b.hsync",      b_hsync,      eb.hs);
        chk("b.vsync",      b_vsync,      eb.vs);
        chk("b.video_on",   b_video_on,   eb.von);
        chk("b.p_tick",     b_p_tick,     eb.pt);
        chk("b.frame_tick", b_frame_tick, eb.ft);
    end

    // Line-0 statistics for instance A: one p_tick sample per pixel state.
    int a_pt_cnt = 0, a_hs_cnt = 0, a_hs_first = -1, a_hs_last = -1;
    always @(negedge clk) begin
        if (!rst_a && a_p_tick && a_pix_y == 10'd0 && k_a < 3300) begin
            a_pt_cnt++;
            if (!a_hsync) begin
                a_hs_cnt++;
                if (a_hs_first < 0) a_hs_first = int'(a_pix_x);
                a_hs_last = int'(a_pix_x);
            end
        end
    end

    // Two-frame window statistics for instance B.
    bit cnt_en = 1'b0;
    int b_ft_cnt = 0, b_vs_cnt = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            if (b_frame_tick) b_ft_cnt++;
            if (b_p_tick && !b_vsync) b_vs_cnt++;
        end
    end

    bit hit;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.hsync",    a_hsync,    1);
        chk("rst.vsync",    a_vsync,    1);
        chk("rst.video_on", a_video_on, 0);
        chk("rst.p_tick",   a_p_tick,   0);
        chk("rst.pix_x",    a_pix_x,    0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First edge after release: still (0,0), visible.
        @(posedge clk); #1;
        chk("first.video_on", a_video_on, 1);
        chk("first.pix_x",    a_pix_x,    0);
        chk("first.pix_y",    a_pix_y,    0);
        chk("first.hsync",    a_hsync,    1);

        // p_tick first high during the 4th clk cycle after release (after edge 3).
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_p_tick) begin hit = 1; break; end
            @(posedge clk); #1;
        end
        chk("ptick_seen", hit, 1);
        chk("ptick_first_edge", k_a, 3);

        // Blanking starts at tick 640 -> edge 2560.
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (a_pix_x == 10'd640) begin hit = 1; break; end
        end
        chk("x640_seen", hit, 1);
        chk("x640_edge", k_a, 2560);
        chk("x640_video_on", a_video_on, 0);

        // Line wrap at tick 800 -> edge 3200.
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (a_pix_y == 10'd1) begin hit = 1; break; end
        end
        chk("line_wrap_seen", hit, 1);
        chk("line_wrap_edge", k_a, 3200);
        chk("line_wrap_x", a_pix_x, 0);
        chk("line0_ptick_cnt", a_pt_cnt, 800);
        chk("line0_hsync_low", a_hs_cnt, 96);
        chk("line0_hsync_first", a_hs_first, 656);
        chk("line0_hsync_last", a_hs_last, 751);

        // Instance B: frame wrap (14,11) -> (0,0) directly.
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (b_pix_x == 10'd14 && b_pix_y == 10'd11 && b_p_tick) begin hit = 1; break; end
        end
        chk("b_corner_seen", hit, 1);
        @(posedge clk); #1;
        chk("b_wrap_x", b_pix_x, 0);
        chk("b_wrap_y", b_pix_y, 0);
        chk("b_wrap_ftick", b_frame_tick, FT_EN);

        // Two full frames (180 clk each at CLK_DIV=1).
        @(negedge clk); #1;
        cnt_en = 1'b1;
        repeat (360) @(negedge clk);
        #1;
        cnt_en = 1'b0;
        chk("b_frame_ticks_2frames", b_ft_cnt, FT_EN ? 2 : 0);
        chk("b_vsync_low_ticks", b_vs_cnt, 60);

        // Asynchronous reset between edges at (7,5).
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (b_pix_x == 10'd7 && b_pix_y == 10'd5) begin hit = 1; break; end
        end
        chk("b_mid_seen", hit, 1);
        @(negedge clk); #2;
        rst_b = 1'b1;
        #1;
        chk("arst.pix_x",    b_pix_x,    0);
        chk("arst.pix_y",    b_pix_y,    0);
        chk("arst.hsync",    b_hsync,    1);
        chk("arst.vsync",    b_vsync,    1);
        chk("arst.video_on", b_video_on, 0);
        chk("arst.p_tick",   b_p_tick,   0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("restart.pix_x",    b_pix_x,    0);
        chk("restart.video_on", b_video_on, 1);
        @(posedge clk); #1;
        chk("restart.advance_x", b_pix_x, 1);

        repeat (200) @(posedge clk);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
